l2_port_arbiter: RTL and testbench

//  Shares the single L2 request port among three L1 requesters: L1I line read, L1D line read, L1D line write-back.

---
 rtl/l2_arb_pkg.sv | 34 +++
 rtl/rr_pick3.sv | 46 ++++
 rtl/l2_port_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l2_arb_pkg
// Description : Shared types for the L2 port arbiter: FSM state encoding,
//               requester identifiers and the round-robin successor helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package l2_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // The value doubles as the bit index into the request vector.
    typedef enum logic [1:0] {
        REQ_I  = 2'd0,
        REQ_DR = 2'd1,
        REQ_DW = 2'd2
    } req_id_t;

    // Successor in the rotation I -> DR -> DW -> I.
    function automatic req_id_t next_req_id(input req_id_t id);
        case (id)
            REQ_I:   next_req_id = REQ_DR;
            REQ_DR:  next_req_id = REQ_DW;
            default: next_req_id = REQ_I;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick3
// Description : Combinational 3-way rotating-priority picker. The search
//               starts at ptr and wraps in the order I, DR, DW.
// Ports       : req   in  3        request vector, bit index = req_id_t
//               ptr   in  req_id_t highest-priority requester this round
//               gnt   out req_id_t selected requester (REQ_I when none)
//               valid out 1        at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick3
    import l2_arb_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_t    ptr,
    output req_id_t    gnt,
    output logic       valid
);

    always_comb begin
        gnt   = REQ_I;
        valid = |req;
        case (ptr)
            REQ_DR: begin
                if (req[1])      gnt = REQ_DR;
                else if (req[2]) gnt = REQ_DW;
                else             gnt = REQ_I;
            end
            REQ_DW: begin
                if (req[2])      gnt = REQ_DW;
                else if (req[0]) gnt = REQ_I;
                else if (req[1]) gnt = REQ_DR;
                else             gnt = REQ_I;
            end
            default: begin
                if (req[0])      gnt = REQ_I;
                else if (req[1]) gnt = REQ_DR;
                else if (req[2]) gnt = REQ_DW;
                else             gnt = REQ_I;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/l2_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l2_port_arbiter
// Description : Shares one L2 request port among the L1I line read, the L1D
//               line read and the L1D line write-back. One L2 transaction at a
//               time, round-robin priority, registered L2 request and a
//               one-cycle completion pulse back to the winner.
//               Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog that aborts
//               a transaction after TIMEOUT_CYC cycles without an L2 hit.
// Ports       : clk, rst (async, active-high)
//               L1I : re_i_i, raddr_i_i -> rdata_i_o, read_hit_i_o
//               L1D : re_d_i, raddr_d_i -> rdata_d_o, read_hit_d_o
//                     we_d_i, waddr_d_i, wdata_d_i -> write_hit_d_o
//               L2  : re_l2_o, raddr_l2_o, we_l2_o, waddr_l2_o, wdata_l2_o
//                     <- rdata_l2_i, read_hit_l2_i, write_hit_l2_i
//               timeout_o : abort pulse (constant 0 without ARB_TIMEOUT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    // L1I read
    input  logic              re_i_i,
    input  logic [ADDR_W-1:0] raddr_i_i,
    output logic [LINE_W-1:0] rdata_i_o,
    output logic              read_hit_i_o,
    // L1D read
    input  logic              re_d_i,
    input  logic [ADDR_W-1:0] raddr_d_i,
    output logic [LINE_W-1:0] rdata_d_o,
    output logic              read_hit_d_o,
    // L1D write-back
    input  logic              we_d_i,
    input  logic [ADDR_W-1:0] waddr_d_i,
    input  logic [LINE_W-1:0] wdata_d_i,
    output logic              write_hit_d_o,
    // L2 port
    output logic              re_l2_o,
    output logic [ADDR_W-1:0] raddr_l2_o,
    input  logic [LINE_W-1:0] rdata_l2_i,
    input  logic              read_hit_l2_i,
    output logic              we_l2_o,
    output logic [ADDR_W-1:0] waddr_l2_o,
    output logic [LINE_W-1:0] wdata_l2_o,
    input  logic              write_hit_l2_i,
    output logic              timeout_o
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    req_id_t           r_rr_ptr;
    req_id_t           r_id;
    req_id_t           w_gnt;
    logic              w_req_valid;
    logic [2:0]        w_req_vec;
    logic              w_grant;
    logic              w_hit_match;
    logic              w_abort;
    logic [LINE_W-1:0] w_ret_data;

    logic              r_re_l2;
    logic              r_we_l2;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rdata_i;
    logic [LINE_W-1:0] r_rdata_d;
    logic              r_hit_i;
    logic              r_hit_rd;
    logic              r_hit_wd;

    assign w_req_vec = {we_d_i, re_d_i, re_i_i};

    rr_pick3 u_pick (
        .req   (w_req_vec),
        .ptr   (r_rr_ptr),
        .gnt   (w_gnt),
        .valid (w_req_valid)
    );

    assign w_grant = (r_state == ARB_IDLE) && w_req_valid;

    // Only the hit type that matches the outstanding transaction counts; a
    // stray hit of the other type is ignored.
    assign w_hit_match = (r_state == ARB_BUSY) &&
                         ((r_id == REQ_DW) ? write_hit_l2_i : read_hit_l2_i);

    // An aborted read returns an all-zero line.
    assign w_ret_data = w_hit_match ? rdata_l2_i : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_CNT_W-1:0] r_busy_cnt;
    logic               r_timeout;

    // r_busy_cnt holds the number of BUSY cycles already elapsed; the abort
    // fires on the edge that closes BUSY cycle number TIMEOUT_CYC.
    assign w_abort = (r_state == ARB_BUSY) && !w_hit_match &&
                     (r_busy_cnt == c_CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if (w_grant) begin
                r_busy_cnt <= '0;
            end else if (r_state == ARB_BUSY) begin
                r_busy_cnt <= r_busy_cnt + c_CNT_W'(1);
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_abort   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: if (w_req_valid) w_state_next = ARB_BUSY;
            ARB_BUSY: if (w_hit_match || w_abort) w_state_next = ARB_RESP;
            ARB_RESP: w_state_next = ARB_IDLE;
            default:  w_state_next = ARB_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction datapath. The async reset clears the L2 request flops so
    // an in-flight request drops the moment rst rises.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= REQ_I;
            r_id      <= REQ_I;
            r_re_l2   <= 1'b0;
            r_we_l2   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_i <= '0;
            r_rdata_d <= '0;
            r_hit_i   <= 1'b0;
            r_hit_rd  <= 1'b0;
            r_hit_wd  <= 1'b0;
        end else begin
            r_hit_i  <= 1'b0;
            r_hit_rd <= 1'b0;
            r_hit_wd <= 1'b0;

            if (w_grant) begin
                r_id     <= w_gnt;
                r_rr_ptr <= next_req_id(w_gnt);
                case (w_gnt)
                    REQ_I: begin
                        r_addr  <= raddr_i_i;
                        r_re_l2 <= 1'b1;
                    end
                    REQ_DR: begin
                        r_addr  <= raddr_d_i;
                        r_re_l2 <= 1'b1;
                    end
                    default: begin
                        r_addr  <= waddr_d_i;
                        r_wdata <= wdata_d_i;
                        r_we_l2 <= 1'b1;
                    end
                endcase
            end

            if (w_hit_match || w_abort) begin
                r_re_l2 <= 1'b0;
                r_we_l2 <= 1'b0;
                case (r_id)
                    REQ_I: begin
                        r_rdata_i <= w_ret_data;
                        r_hit_i   <= 1'b1;
                    end
                    REQ_DR: begin
                        r_rdata_d <= w_ret_data;
                        r_hit_rd  <= 1'b1;
                    end
                    default: begin
                        r_hit_wd <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign re_l2_o       = r_re_l2;
    assign we_l2_o       = r_we_l2;
    assign raddr_l2_o    = r_re_l2 ? r_addr : '0;
    assign waddr_l2_o    = r_we_l2 ? r_addr : '0;
    assign wdata_l2_o    = r_we_l2 ? r_wdata : '0;
    assign rdata_i_o     = r_rdata_i;
    assign rdata_d_o     = r_rdata_d;
    assign read_hit_i_o  = r_hit_i;
    assign read_hit_d_o  = r_hit_rd;
    assign write_hit_d_o = r_hit_wd;

endmodule
`default_nettype wire

// File: tb/tb_l2_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_l2_port_arbiter
// Description : Self-checking bench for l2_port_arbiter. Build with
//               +define+ARB_TIMEOUT_EN to exercise the BUSY watchdog
//               (TIMEOUT_CYC = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              re_i_i = 1'b0;
    logic [ADDR_W-1:0] raddr_i_i = '0;
    logic [LINE_W-1:0] rdata_i_o;
    logic              read_hit_i_o;
    logic              re_d_i = 1'b0;
    logic [ADDR_W-1:0] raddr_d_i = '0;
    logic [LINE_W-1:0] rdata_d_o;
    logic              read_hit_d_o;
    logic              we_d_i = 1'b0;
    logic [ADDR_W-1:0] waddr_d_i = '0;
    logic [LINE_W-1:0] wdata_d_i = '0;
    logic              write_hit_d_o;
    logic              re_l2_o;
    logic [ADDR_W-1:0] raddr_l2_o;
    logic [LINE_W-1:0] rdata_l2_i = '0;
    logic              read_hit_l2_i = 1'b0;
    logic              we_l2_o;
    logic [ADDR_W-1:0] waddr_l2_o;
    logic [LINE_W-1:0] wdata_l2_o;
    logic              write_hit_l2_i = 1'b0;
    logic              timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        req_id_t           id;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    l2_port_arbiter #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .re_i_i         (re_i_i),
        .raddr_i_i      (raddr_i_i),
        .rdata_i_o      (rdata_i_o),
        .read_hit_i_o   (read_hit_i_o),
        .re_d_i         (re_d_i),
        .raddr_d_i      (raddr_d_i),
        .rdata_d_o      (rdata_d_o),
        .read_hit_d_o   (read_hit_d_o),
        .we_d_i         (we_d_i),
        .waddr_d_i      (waddr_d_i),
        .wdata_d_i      (wdata_d_i),
        .write_hit_d_o  (write_hit_d_o),
        .re_l2_o        (re_l2_o),
        .raddr_l2_o     (raddr_l2_o),
        .rdata_l2_i     (rdata_l2_i),
        .read_hit_l2_i  (read_hit_l2_i),
        .we_l2_o        (we_l2_o),
        .waddr_l2_o     (waddr_l2_o),
        .wdata_l2_o     (wdata_l2_o),
        .write_hit_l2_i (write_hit_l2_i),
        .timeout_o      (timeout_o)
    );

    // Outputs are sampled and inputs driven on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for an L2 request; ok=0 when the budget expires.
    task automatic wait_l2_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (re_l2_o || we_l2_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drop_all();
        re_i_i = 1'b0; re_d_i = 1'b0; we_d_i = 1'b0;
        read_hit_l2_i = 1'b0; write_hit_l2_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drop_all();
        repeat (2) tick();
        n_tests++;
        if ({re_l2_o, we_l2_o, read_hit_i_o, read_hit_d_o, write_hit_d_o, timeout_o} !== 6'b0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                {re_l2_o, we_l2_o, read_hit_i_o, read_hit_d_o, write_hit_d_o, timeout_o}); end
        n_tests++;
        if (rdata_i_o !== '0 || rdata_d_o !== '0 || wdata_l2_o !== '0 || raddr_l2_o !== '0 || waddr_l2_o !== '0)
            begin n_fail++; $display("FAIL reset_data: got rdi=%h rdd=%h expected 0", rdata_i_o, rdata_d_o); end
        rst = 1'b0;
        tick();
        n_tests++;
        if (re_l2_o !== 1'b0 || we_l2_o !== 1'b0)
            begin n_fail++; $display("FAIL idle_no_req: got re=%b we=%b expected 0 0", re_l2_o, we_l2_o); end
    endtask

    task automatic test_single_read();
        logic [LINE_W-1:0] d;
        int cyc;
        bit early;
        d = {32{8'hA5}};
        re_i_i = 1'b1; raddr_i_i = 32'h0000_1000;
        tick();
        n_tests++;
        if (re_l2_o !== 1'b1 || we_l2_o !== 1'b0 || raddr_l2_o !== 32'h0000_1000)
            begin n_fail++; $display("FAIL single_req: got re=%b we=%b addr=%h expected 1 0 00001000",
                re_l2_o, we_l2_o, raddr_l2_o); end
        cyc = 0; early = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (re_l2_o) cyc++;
            if (read_hit_i_o || read_hit_d_o || write_hit_d_o) early = 1'b1;
            if (i == 2) begin read_hit_l2_i = 1'b1; rdata_l2_i = d; end
            tick();
        end
        read_hit_l2_i = 1'b0; re_i_i = 1'b0;
        n_tests++;
        if (cyc != 3 || early)
            begin n_fail++; $display("FAIL single_busy: got cycles=%0d early_hit=%b expected 3 0", cyc, early); end
        n_tests++;
        if ({read_hit_i_o, read_hit_d_o, write_hit_d_o, re_l2_o} !== 4'b1000 || rdata_i_o !== d)
            begin n_fail++; $display("FAIL single_hit: got hits=%b re=%b rdata=%h expected 100 0 %h",
                {read_hit_i_o, read_hit_d_o, write_hit_d_o}, re_l2_o, rdata_i_o, d); end
        tick();
        n_tests++;
        if (read_hit_i_o !== 1'b0)
            begin n_fail++; $display("FAIL single_pulse: got read_hit_i_o=%b expected 0", read_hit_i_o); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        bit ok;
        realtime t_prev;
        logic [ADDR_W-1:0] got_addr;
        rst = 1'b1; tick(); rst = 1'b0;
        raddr_i_i = 32'h100; raddr_d_i = 32'h200; waddr_d_i = 32'h300;
        wdata_d_i = {8{32'h1234_5678}};
        for (int k = 0; k < 6; k++) begin
            e.id   = req_id_t'(k % 3);
            e.addr = (e.id == REQ_I) ? 32'h100 : (e.id == REQ_DR) ? 32'h200 : 32'h300;
            e.data = {8{32'hC0DE_0000 + 32'(k)}};
            sb.push_back(e);
        end
        re_i_i = 1'b1; re_d_i = 1'b1; we_d_i = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_l2_req(ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL rr_wait[%0d]: got no L2 request expected id=%0d", k, e.id);
                break;
            end
            if (k > 0) begin
                n_tests++;
                if ($realtime - t_prev != 30.0)
                    begin n_fail++; $display("FAIL rr_throughput[%0d]: got %0t ns expected 30 ns", k, $realtime - t_prev); end
            end
            t_prev = $realtime;
            got_addr = we_l2_o ? waddr_l2_o : raddr_l2_o;
            if (we_l2_o !== (e.id == REQ_DW) || re_l2_o !== (e.id != REQ_DW) || got_addr !== e.addr ||
                (e.id == REQ_DW && wdata_l2_o !== wdata_d_i))
                begin n_fail++; $display("FAIL rr_grant[%0d]: got re=%b we=%b addr=%h expected id=%0d addr=%h",
                    k, re_l2_o, we_l2_o, got_addr, e.id, e.addr); end
            rdata_l2_i = e.data;
            if (e.id == REQ_DW) write_hit_l2_i = 1'b1; else read_hit_l2_i = 1'b1;
            tick();
            read_hit_l2_i = 1'b0; write_hit_l2_i = 1'b0;
            n_tests++;
            if ({read_hit_i_o, read_hit_d_o, write_hit_d_o} !== (3'b100 >> e.id))
                begin n_fail++; $display("FAIL rr_hit[%0d]: got %b expected %b", k,
                    {read_hit_i_o, read_hit_d_o, write_hit_d_o}, 3'b100 >> e.id); end
            if (e.id != REQ_DW) begin
                n_tests++;
                if ((e.id == REQ_I ? rdata_i_o : rdata_d_o) !== e.data)
                    begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h expected %h", k,
                        (e.id == REQ_I ? rdata_i_o : rdata_d_o), e.data); end
            end
        end
        drop_all();
        tick(); tick();
    endtask

    task automatic test_resp_hold();
        bit ok;
        rst = 1'b1; tick(); rst = 1'b0;
        re_i_i = 1'b1; raddr_i_i = 32'h4000;
        wait_l2_req(ok);
        read_hit_l2_i = 1'b1; rdata_l2_i = '1;
        tick();
        read_hit_l2_i = 1'b0;
        n_tests++;
        if (!ok || read_hit_i_o !== 1'b1)
            begin n_fail++; $display("FAIL hold_first: got ok=%b hit=%b expected 1 1", ok, read_hit_i_o); end
        tick();
        n_tests++;
        if (re_l2_o !== 1'b0)
            begin n_fail++; $display("FAIL hold_resp_ignored: got re_l2_o=%b expected 0", re_l2_o); end
        tick();
        n_tests++;
        if (re_l2_o !== 1'b1 || raddr_l2_o !== 32'h4000)
            begin n_fail++; $display("FAIL hold_regrant: got re=%b addr=%h expected 1 00004000", re_l2_o, raddr_l2_o); end
        read_hit_l2_i = 1'b1;
        tick();
        read_hit_l2_i = 1'b0; re_i_i = 1'b0;
        tick(); tick();
        n_tests++;
        if (re_l2_o !== 1'b0 || we_l2_o !== 1'b0)
            begin n_fail++; $display("FAIL hold_dropped: got re=%b we=%b expected 0 0", re_l2_o, we_l2_o); end
    endtask

    task automatic test_write();
        bit ok;
        bit bad;
        logic [LINE_W-1:0] wd;
        wd = {32{8'h5A}};
        we_d_i = 1'b1; waddr_d_i = 32'h2000; wdata_d_i = wd;
        wait_l2_req(ok);
        n_tests++;
        if (!ok || we_l2_o !== 1'b1 || re_l2_o !== 1'b0 || waddr_l2_o !== 32'h2000 || wdata_l2_o !== wd)
            begin n_fail++; $display("FAIL wr_req: got we=%b re=%b addr=%h expected 1 0 00002000",
                we_l2_o, re_l2_o, waddr_l2_o); end
        // Requester withdraws and changes its inputs; a wrong-type hit arrives.
        we_d_i = 1'b0; waddr_d_i = 32'hDEAD; wdata_d_i = '0;
        read_hit_l2_i = 1'b1; rdata_l2_i = '1;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            read_hit_l2_i = 1'b0;
            if (we_l2_o !== 1'b1 || waddr_l2_o !== 32'h2000 || wdata_l2_o !== wd ||
                read_hit_i_o || read_hit_d_o || write_hit_d_o) bad = 1'b1;
        end
        n_tests++;
        if (bad)
            begin n_fail++; $display("FAIL wr_stable: got we=%b addr=%h hits=%b expected 1 00002000 000",
                we_l2_o, waddr_l2_o, {read_hit_i_o, read_hit_d_o, write_hit_d_o}); end
        write_hit_l2_i = 1'b1;
        tick();
        write_hit_l2_i = 1'b0;
        n_tests++;
        if ({read_hit_i_o, read_hit_d_o, write_hit_d_o, we_l2_o} !== 4'b0010)
            begin n_fail++; $display("FAIL wr_hit: got hits=%b we=%b expected 001 0",
                {read_hit_i_o, read_hit_d_o, write_hit_d_o}, we_l2_o); end
        tick();
        n_tests++;
        if (write_hit_d_o !== 1'b0)
            begin n_fail++; $display("FAIL wr_pulse: got write_hit_d_o=%b expected 0", write_hit_d_o); end
    endtask

    task automatic test_reset_mid_busy();
        bit ok;
        bit bad;
        re_d_i = 1'b1; raddr_d_i = 32'h3000;
        wait_l2_req(ok);
        n_tests++;
        if (!ok || re_l2_o !== 1'b1 || raddr_l2_o !== 32'h3000)
            begin n_fail++; $display("FAIL rstb_req: got ok=%b re=%b addr=%h expected 1 1 00003000",
                ok, re_l2_o, raddr_l2_o); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (re_l2_o !== 1'b0)
            begin n_fail++; $display("FAIL rstb_async_drop: got re_l2_o=%b expected 0", re_l2_o); end
        re_d_i = 1'b0;
        tick();
        rst = 1'b0;
        read_hit_l2_i = 1'b1; rdata_l2_i = {8{32'hBAD0_BAD0}};
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (read_hit_i_o || read_hit_d_o || write_hit_d_o || re_l2_o || we_l2_o) bad = 1'b1;
        end
        read_hit_l2_i = 1'b0;
        n_tests++;
        if (bad || rdata_d_o !== '0)
            begin n_fail++; $display("FAIL rstb_late_hit: got hits=%b re=%b rdd=%h expected 000 0 0",
                {read_hit_i_o, read_hit_d_o, write_hit_d_o}, re_l2_o, rdata_d_o); end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        bit early;
        int cyc;
        re_d_i = 1'b1; raddr_d_i = 32'h5000;
        wait_l2_req(ok);
        cyc = 0; early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!re_l2_o) break;
            cyc++;
            if (timeout_o || read_hit_d_o) early = 1'b1;
            tick();
        end
        re_d_i = 1'b0;
        n_tests++;
        if (!ok || cyc != 8 || early)
            begin n_fail++; $display("FAIL to_busy_len: got %0d cycles early=%b expected 8 0", cyc, early); end
        n_tests++;
        if (timeout_o !== 1'b1 || read_hit_d_o !== 1'b1 || read_hit_i_o !== 1'b0 || rdata_d_o !== '0)
            begin n_fail++; $display("FAIL to_abort: got to=%b hit_d=%b rdd=%h expected 1 1 0",
                timeout_o, read_hit_d_o, rdata_d_o); end
        tick();
        n_tests++;
        if (timeout_o !== 1'b0 || read_hit_d_o !== 1'b0)
            begin n_fail++; $display("FAIL to_pulse: got to=%b hit_d=%b expected 0 0", timeout_o, read_hit_d_o); end
    endtask
`else
    task automatic test_timeout();
        bit ok;
        bit bad;
        re_d_i = 1'b1; raddr_d_i = 32'h5000;
        wait_l2_req(ok);
        re_d_i = 1'b0;
        bad = !ok;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (re_l2_o !== 1'b1 || timeout_o !== 1'b0 || read_hit_d_o !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad)
            begin n_fail++; $display("FAIL no_timeout_wait: got re=%b to=%b expected 1 0", re_l2_o, timeout_o); end
        read_hit_l2_i = 1'b1; rdata_l2_i = {8{32'h0F0F_0F0F}};
        tick();
        read_hit_l2_i = 1'b0;
        n_tests++;
        if (read_hit_d_o !== 1'b1 || rdata_d_o !== {8{32'h0F0F_0F0F}} || timeout_o !== 1'b0)
            begin n_fail++; $display("FAIL no_timeout_hit: got hit_d=%b to=%b rdd=%h expected 1 0 0f0f..",
                read_hit_d_o, timeout_o, rdata_d_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_resp_hold();
        test_write();
        test_reset_mid_busy();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
